// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------
// Sequences single-word loads, single-word stores and forward block copies
// against a synchronous-read data memory (read data appears the cycle after
// the address is presented).
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready.
// req_ready is high only while the unit is idle, and every req_* field is
// captured on that edge, so the requester may change them freely afterwards.
// Completion is reported by a one-cycle done pulse; err is meaningful only
// while done is high.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake
//   req_op              00 load, 01 store, 10 block copy, 11 reserved
//   req_addr            load/store address, copy source base
//   req_dst, req_len    copy destination base and length in words
//   req_wdata           store data
//   done, err           completion pulse, reserved-op flag
//   rdata               last load result
//   mem_addr/mem_wen/mem_din/mem_dout  memory port
//   dbg_state           current FSM state, for observation only
module mem_access_unit #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_dst,
    input  logic [ADDR_W-1:0] req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_ADDR = 3'd1,
        S_LD_DATA = 3'd2,
        S_ST      = 3'd3,
        S_CP_RD   = 3'd4,
        S_CP_WR   = 3'd5,
        S_DONE    = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    // Last address driven; keeps mem_addr stable while the unit is idle.
    logic [ADDR_W-1:0]   maddr_q, maddr_d;

    logic [ADDR_W-1:0]   mem_addr_c;
    logic                mem_wen_c;
    logic [DATA_W-1:0]   mem_din_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            maddr_q <= maddr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dst_d      = dst_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        mem_addr_c = maddr_q;
        mem_wen_c  = 1'b0;
        mem_din_c  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    dst_d   = req_dst;
                    len_d   = req_len;
                    wdata_d = req_wdata;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    unique case (req_op)
                        2'b00: state_d = S_LD_ADDR;
                        2'b01: state_d = S_ST;
                        2'b10: state_d = (req_len == '0) ? S_DONE : S_CP_RD;
                        default: begin
                            state_d = S_DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_LD_ADDR: begin
                mem_addr_c = addr_q;
                state_d    = S_LD_DATA;
            end
            S_LD_DATA: begin
                // Memory has registered addr_q on the previous edge.
                rdata_d = mem_dout;
                state_d = S_DONE;
            end
            S_ST: begin
                mem_addr_c = addr_q;
                mem_din_c  = wdata_q;
                mem_wen_c  = 1'b1;
                state_d    = S_DONE;
            end
            S_CP_RD: begin
                mem_addr_c = addr_q + idx_q;
                state_d    = S_CP_WR;
            end
            S_CP_WR: begin
                // mem_dout holds the source word fetched in CP_RD; because each
                // read follows the previous write, overlapping ranges copy forward.
                mem_addr_c = dst_q + idx_q;
                mem_din_c  = mem_dout;
                mem_wen_c  = 1'b1;
                if (idx_q == len_q - ADDR_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = S_CP_RD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        maddr_d = mem_addr_c;
    end

    assign req_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = done & err_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_c;
    // Gated by rst so an abort suppresses the write in the same cycle.
    assign mem_wen   = mem_wen_c & ~rst;
    assign mem_din   = mem_din_c;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int MEM_WORDS = 1 << AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = '0;
    logic [AW-1:0] req_addr = '0;
    logic [AW-1:0] req_dst = '0;
    logic [AW-1:0] req_len = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          done;
    logic          err;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic [2:0]    dbg_state;

    mem_access_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_dst   (req_dst),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .dbg_state (dbg_state)
    );

    // ---------------- synchronous-read memory ----------------
    logic          mem_clear = 1'b1;
    logic [DW-1:0] ram [MEM_WORDS];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int k = 0; k < MEM_WORDS; k++) ram[k] <= '0;
            mem_dout <= '0;
        end else begin
            if (mem_wen) ram[mem_addr] <= mem_din;
            mem_dout <= ram[mem_addr];
        end
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_ram [MEM_WORDS];
    logic [DW-1:0] exp_rdata;

    function automatic int exp_latency(input logic [1:0] op, input int len);
        case (op)
            2'b00:   return 3;
            2'b01:   return 2;
            2'b10:   return (len == 0) ? 1 : 2 * len + 1;
            default: return 1;
        endcase
    endfunction

    function automatic int exp_writes(input logic [1:0] op, input int len);
        case (op)
            2'b01:   return 1;
            2'b10:   return len;
            default: return 0;
        endcase
    endfunction

    // Applies one completed request to the reference image; a copy moves word
    // by word from the lowest index up, so overlaps copy forward.
    task automatic ref_apply(input logic [1:0] op, input logic [AW-1:0] a,
                             input logic [AW-1:0] d, input int len, input logic [DW-1:0] w);
        case (op)
            2'b00: exp_rdata = ref_ram[a];
            2'b01: ref_ram[a] = w;
            2'b10: for (int k = 0; k < len; k++) ref_ram[AW'(d + k)] = ref_ram[AW'(a + k)];
            default: ;
        endcase
    endtask

    function automatic int mem_mismatches();
        int n = 0;
        for (int k = 0; k < MEM_WORDS; k++) if (ram[k] !== ref_ram[k]) n++;
        return n;
    endfunction

    // ---------------- scoreboard ----------------
    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns just after the accepting rising edge.
    task automatic start_req(input logic [1:0] op, input logic [AW-1:0] a,
                             input logic [AW-1:0] d, input logic [AW-1:0] l,
                             input logic [DW-1:0] w);
        int guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_dst   = d;
        req_len   = l;
        req_wdata = w;
        @(posedge clk);
        #1;
        // Scramble the request after acceptance; the unit must ignore this.
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = AW'($urandom);
        req_dst   = AW'($urandom);
        req_len   = AW'($urandom);
        req_wdata = DW'($urandom);
    endtask

    // Full request: issue, wait for done, check latency, writes, err, rdata, memory.
    task automatic run_req(input string tag, input logic [1:0] op, input logic [AW-1:0] a,
                           input logic [AW-1:0] d, input logic [AW-1:0] l,
                           input logic [DW-1:0] w);
        int cycles = 0;
        int wens   = 0;
        int errbad = 0;
        logic seen_done = 1'b0;
        start_req(op, a, d, l, w);
        while (!seen_done && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            if (mem_wen) wens++;
            if (done) seen_done = 1'b1;
            else if (err) errbad++;
        end
        ref_apply(op, a, d, int'(l), w);
        check({tag, "_done_seen"}, {31'd0, seen_done}, 32'd1);
        check({tag, "_latency"}, cycles, exp_latency(op, int'(l)));
        check({tag, "_writes"}, wens, exp_writes(op, int'(l)));
        check({tag, "_err"}, {31'd0, err}, {31'd0, op == 2'b11});
        check({tag, "_err_outside_done"}, errbad, 0);
        check({tag, "_rdata"}, {16'd0, rdata}, {16'd0, exp_rdata});
        check({tag, "_mem_image"}, mem_mismatches(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0]    op;
        logic [AW-1:0] a, d, l;
        logic [DW-1:0] w;
        int cyc;
        int wens;
        int dones;

        for (int k = 0; k < MEM_WORDS; k++) ref_ram[k] = '0;
        exp_rdata = '0;

        // Reset, with a request pending to show reset wins.
        req_valid = 1'b1;
        req_op    = 2'b01;
        repeat (3) @(negedge clk);
        check("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        rst = 1'b0;
        mem_clear = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        check("rst_mem_din", {16'd0, mem_din}, 32'd0);

        // Directed: store then load.
        run_req("store_beef", 2'b01, 10'h005, 10'h000, 10'h000, 16'hBEEF);
        @(negedge clk);
        check("idle_mem_addr_hold", {22'd0, mem_addr}, 32'h005);
        check("idle_mem_din_zero", {16'd0, mem_din}, 32'd0);
        check("idle_mem_wen_zero", {31'd0, mem_wen}, 32'd0);
        run_req("load_beef", 2'b00, 10'h005, 10'h000, 10'h000, 16'h0000);
        check("load_beef_value", {16'd0, rdata}, 32'hBEEF);

        // Directed: wrapping-source copy.
        run_req("pre_3fe", 2'b01, 10'h3FE, 10'h0, 10'h0, 16'd1);
        run_req("pre_3ff", 2'b01, 10'h3FF, 10'h0, 10'h0, 16'd2);
        run_req("pre_000", 2'b01, 10'h000, 10'h0, 10'h0, 16'd3);
        run_req("pre_001", 2'b01, 10'h001, 10'h0, 10'h0, 16'd4);
        run_req("copy_wrap", 2'b10, 10'h3FE, 10'h010, 10'd4, 16'h0);
        check("copy_wrap_w3", {16'd0, ram[10'h013]}, 32'd4);

        // Directed: overlapping forward copy replicates the source word.
        run_req("pre_020", 2'b01, 10'h020, 10'h0, 10'h0, 16'h000A);
        run_req("copy_overlap", 2'b10, 10'h020, 10'h021, 10'd3, 16'h0);
        check("copy_overlap_023", {16'd0, ram[10'h023]}, 32'h000A);

        // Directed: reserved op and zero-length copy; rdata must stay BEEF.
        run_req("reserved", 2'b11, 10'h005, 10'h005, 10'd5, 16'h1234);
        run_req("copy_len0", 2'b10, 10'h020, 10'h030, 10'd0, 16'h0);
        check("rdata_held", {16'd0, rdata}, 32'hBEEF);

        // Directed: reset during CP_WR of index 2 in a length-8 copy.
        for (int k = 0; k < 8; k++)
            run_req("pre_abort", 2'b01, AW'(10'h100 + k), 10'h0, 10'h0, DW'(16'h0500 + k));
        start_req(2'b10, 10'h100, 10'h200, 10'd8, 16'h0);
        // Falling edges 2,4,6 after accept are CP_WR for indices 0,1,2.
        for (int k = 0; k < 6; k++) @(negedge clk);
        check("abort_wen_before", {31'd0, mem_wen}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_wen_gated", {31'd0, mem_wen}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ref_ram[10'h200] = ref_ram[10'h100];
        ref_ram[10'h201] = ref_ram[10'h101];
        exp_rdata = '0;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_rdata", {16'd0, rdata}, 32'd0);
        wens = 0;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            if (mem_wen) wens++;
            if (done) dones++;
            @(negedge clk);
        end
        check("abort_no_writes", wens, 0);
        check("abort_no_done", dones, 0);
        check("abort_mem_image", mem_mismatches(), 0);

        // Large copies: near-full length with forward overlap, and a dest wrap.
        run_req("copy_1023", 2'b10, 10'h3F0, 10'h3F1, 10'd1023, 16'h0);
        run_req("copy_wrap_dst", 2'b10, 10'h040, 10'h3F8, 10'd300, 16'h0);

        // Randomized requests against the reference model.
        cyc = 0;
        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7 && op == 2'b11) op = 2'b01;
            a = AW'($urandom);
            d = ($urandom_range(0, 3) == 0) ? AW'(a + 10'd1) : AW'($urandom);
            l = AW'($urandom_range(0, 24));
            w = DW'($urandom);
            run_req("rand", op, a, d, l, w);
            cyc++;
        end
        check("rand_count", cyc, 60);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global time bound so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, expected finish before bound");
        $fatal(1, "timeout");
    end

endmodule
